// File: rtl/mips_isa_pkg.sv
// MIPS-style ISA constants shared by the program loader and the instruction decoder.
// Holds the opcode/funct map, the symbolic mnemonic codes and the loader FSM state type.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd25;
    localparam logic [5:0] OP_LW    = 6'd47;
    localparam logic [5:0] OP_SW    = 6'd48;
    localparam logic [5:0] OP_BNE   = 6'd49;
    localparam logic [5:0] OP_ADDI  = 6'd50;
    localparam logic [5:0] OP_ORI   = 6'd51;
    localparam logic [5:0] OP_JMP   = 6'd2;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_MUL = 6'd50;

    localparam logic [3:0] MN_ADD  = 4'd0;
    localparam logic [3:0] MN_SUB  = 4'd1;
    localparam logic [3:0] MN_AND  = 4'd2;
    localparam logic [3:0] MN_OR   = 4'd3;
    localparam logic [3:0] MN_MUL  = 4'd4;
    localparam logic [3:0] MN_LW   = 4'd5;
    localparam logic [3:0] MN_SW   = 4'd6;
    localparam logic [3:0] MN_BNE  = 4'd7;
    localparam logic [3:0] MN_ADDI = 4'd8;
    localparam logic [3:0] MN_ORI  = 4'd9;
    localparam logic [3:0] MN_JMP  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/mips_instr_encoder.sv
// Combinational encoder: symbolic mnemonic plus operand fields -> 32-bit instruction word.
// Unknown mnemonics produce a zero word with illegal raised.
module mips_instr_encoder
    import mips_isa_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Opcode/funct lookup for every supported mnemonic.
    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            MN_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            MN_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            MN_MUL:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_MUL};
            MN_LW:   word = {OP_LW,   rs, rt, imm};
            MN_SW:   word = {OP_SW,   rs, rt, imm};
            MN_BNE:  word = {OP_BNE,  rs, rt, imm};
            MN_ADDI: word = {OP_ADDI, rs, rt, imm};
            MN_ORI:  word = {OP_ORI,  rs, rt, imm};
            MN_JMP:  word = {OP_JMP,  target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Streams symbolic instructions in, encodes them and writes the words to consecutive
// instruction-memory addresses, tracking word count, sticky errors and an end-of-load pulse.
module imem_program_loader
    import mips_isa_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_mnem,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic [1:0]    err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    ld_state_e     state_r;
    ld_state_e     state_s;
    logic [AW-1:0] ptr_r;
    logic          last_r;
    logic          ovf_r;
    logic          hs_s;
    logic          full_s;
    logic [31:0]   word_s;
    logic          illegal_s;

    assign hs_s   = (state_r == ST_LOAD) && in_valid && in_ready;
    assign full_s = (count == DEPTH_C);

    mips_instr_encoder u_enc (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (word_s),
        .illegal (illegal_s)
    );

    // Next-state logic; start overrides everything, including a same-cycle handshake.
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = ST_IDLE;
                ST_LOAD:  state_s = hs_s ? ST_WRITE : ST_LOAD;
                ST_WRITE: state_s = (last_r || ovf_r) ? ST_DONE : ST_LOAD;
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State register and the handshake/status outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            in_ready <= (state_s == ST_LOAD);
            done     <= (state_s == ST_DONE);
        end
    end

    // Write datapath: the word is registered at the handshake edge so the strobe lands
    // in the WRITE cycle; ptr/count advance only for words actually written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            ptr_r      <= '0;
            count      <= '0;
            err        <= 2'b00;
            last_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                ptr_r  <= start_addr;
                count  <= '0;
                err    <= 2'b00;
                last_r <= 1'b0;
                ovf_r  <= 1'b0;
            end else if (hs_s) begin
                last_r <= in_last;
                ovf_r  <= full_s;
                if (full_s) begin
                    err[1] <= 1'b1;
                end else if (illegal_s) begin
                    err[0] <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr_r;
                    imem_wdata <= word_s;
                    ptr_r      <= ptr_r + AW'(1);
                    count      <= count + (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed-plus-random bench for imem_program_loader with a program-level reference model.
module tb_imem_program_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_mnem;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic [1:0]    err;

    always #5 clk = ~clk;

    imem_program_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
        .done(done), .err(err)
    );

    typedef struct packed {
        logic [3:0]  mn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
    } instr_t;

    instr_t            prog[$];
    logic [AW+31:0]    got_q[$];
    logic [AW+31:0]    exp_q[$];
    int                n_checks = 0;
    int                n_errs   = 0;

    always @(negedge clk) if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});

    // Reference encoding built from the opcode table with plain arithmetic.
    function automatic logic [31:0] ref_enc(input instr_t x);
        int    fn_tab[5] = '{32, 34, 36, 37, 50};
        int    op_tab[5] = '{47, 48, 49, 50, 51};
        longint v;
        int    m;
        m = int'(x.mn);
        if (m <= 4)
            v = 64'd25 * 64'd67108864 + longint'(x.rs) * 64'd2097152 + longint'(x.rt) * 64'd65536
                + longint'(x.rd) * 64'd2048 + longint'(fn_tab[m]);
        else if (m <= 9)
            v = longint'(op_tab[m-5]) * 64'd67108864 + longint'(x.rs) * 64'd2097152
                + longint'(x.rt) * 64'd65536 + longint'(x.imm);
        else
            v = 64'd2 * 64'd67108864 + longint'(x.tgt);
        return v[31:0];
    endfunction

    function automatic instr_t mk(input int mn, input int rs, input int rt, input int rd,
                                  input int imm, input int tgt, input bit last);
        instr_t x;
        x.mn = 4'(mn); x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
        x.imm = 16'(imm); x.tgt = 26'(tgt); x.last = last;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic scramble();
        in_mnem = 4'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
        in_imm = 16'($urandom); in_target = 26'($urandom); in_last = 1'($urandom);
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        start = 1'b1; start_addr = a;
        tick();
        start = 1'b0; start_addr = AW'($urandom);
    endtask

    task automatic send(input instr_t x, input logic exp_we);
        for (int k = 0; k < 20 && in_ready !== 1'b1; k++) tick();
        chk("in_ready_wait", in_ready, 1'b1);
        repeat ($urandom_range(0, 2)) tick();
        in_mnem = x.mn; in_rs = x.rs; in_rt = x.rt; in_rd = x.rd;
        in_imm = x.imm; in_target = x.tgt; in_last = x.last; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        chk("we_latency", imem_we, exp_we);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 10 && done !== 1'b1; k++) tick();
        chk("done_pulse", done, 1'b1);
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("ready_idle", in_ready, 1'b0);
    endtask

    // Runs prog from sa, predicting writes/count/err from the loader's program-level rules.
    task automatic run_prog(input logic [AW-1:0] sa);
        int            cnt;
        logic [1:0]    e;
        bit            stop, ovf, ill;
        logic [AW-1:0] a;
        cnt = 0; e = 2'b00; stop = 1'b0;
        got_q.delete(); exp_q.delete();
        pulse_start(sa);
        chk("ready_after_start", in_ready, 1'b1);
        for (int i = 0; i < prog.size(); i++) begin
            if (!stop) begin
                ovf = (cnt == DEPTH);
                ill = (prog[i].mn > 4'd10);
                send(prog[i], !ovf && !ill);
                if (ovf) begin
                    e[1] = 1'b1; stop = 1'b1;
                end else if (ill) begin
                    e[0] = 1'b1;
                end else begin
                    a = AW'(int'(sa) + cnt);
                    exp_q.push_back({a, ref_enc(prog[i])});
                    cnt++;
                end
                if (prog[i].last) stop = 1'b1;
            end
        end
        wait_done();
        chk("count", count, cnt);
        chk("err", err, e);
        chk("n_writes", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("write", got_q[i], exp_q[i]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0;
        scramble();
        #12;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr_data", {imem_addr, imem_wdata}, 0);
        chk("rst_count_err", {count, err}, 0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Inputs ignored while idle.
        in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        chk("idle_no_write", imem_we, 1'b0);
        chk("idle_no_ready", in_ready, 1'b0);

        prog = '{mk(0, 1, 2, 3, 0, 0, 1'b1)};
        run_prog(5'd0);
        chk("add_word", (got_q.size() > 0) ? got_q[0] : 37'd0, {5'd0, 32'h64221820});

        prog = '{mk(5, 4, 5, 0, 16'h0010, 0, 1'b0), mk(4, 1, 1, 2, 0, 0, 1'b0),
                 mk(10, 0, 0, 0, 0, 26'h40, 1'b1)};
        run_prog(5'd0);
        chk("lw_word",  (got_q.size() > 0) ? got_q[0] : 37'd0, {5'd0, 32'hBC850010});
        chk("mul_word", (got_q.size() > 1) ? got_q[1] : 37'd0, {5'd1, 32'h64211032});
        chk("jmp_word", (got_q.size() > 2) ? got_q[2] : 37'd0, {5'd2, 32'h08000040});

        prog = '{mk(7, 0, 0, 0, 16'hFFFF, 0, 1'b0), mk(12, 0, 0, 0, 0, 0, 1'b1)};
        run_prog(5'd0);
        chk("bne_word", (got_q.size() > 0) ? got_q[0] : 37'd0, {5'd0, 32'hC400FFFF});
        chk("bne_err", err, 2'b01);

        prog.delete();
        for (int i = 0; i <= DEPTH; i++) prog.push_back(mk(0, i, i, i, 0, 0, 1'b0));
        run_prog(5'd3);
        chk("ovf_err", err, 2'b10);
        chk("ovf_count", count, DEPTH);

        prog = '{mk(9, 7, 8, 0, 16'h1234, 0, 1'b0), mk(3, 9, 10, 11, 0, 0, 1'b1)};
        run_prog(5'd31);
        chk("wrap_addr0", (got_q.size() > 0) ? got_q[0][AW+31:32] : 5'd0, 5'd31);
        chk("wrap_addr1", (got_q.size() > 1) ? got_q[1][AW+31:32] : 5'd1, 5'd0);

        // Restart mid-load with a simultaneous handshake: start wins, errors cleared.
        pulse_start(5'd4);
        send(mk(15, 0, 0, 0, 0, 0, 1'b0), 1'b0);
        send(mk(1, 1, 2, 3, 0, 0, 1'b0), 1'b1);
        tick();
        chk("mid_err_set", err, 2'b01);
        got_q.delete();
        start = 1'b1; start_addr = 5'd10; in_valid = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("restart_count", count, 0);
        chk("restart_err", err, 2'b00);
        chk("restart_we", imem_we, 1'b0);
        chk("restart_ready", in_ready, 1'b1);
        send(mk(2, 5, 6, 7, 0, 0, 1'b1), 1'b1);
        wait_done();
        chk("restart_write", (got_q.size() == 1) ? got_q[0] : 37'd0,
            {5'd10, ref_enc(mk(2, 5, 6, 7, 0, 0, 1'b1))});

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, DEPTH + 2);
            prog.delete();
            for (int i = 0; i < n; i++)
                prog.push_back(mk($urandom_range(0, 12), $urandom, $urandom, $urandom,
                                  $urandom, $urandom, i == n - 1));
            run_prog(AW'($urandom));
        end

        // Reset during a write cycle.
        pulse_start(5'd0);
        send(mk(0, 1, 1, 1, 0, 0, 1'b0), 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", imem_we, 1'b0);
        chk("rst_mid_ready", in_ready, 1'b0);
        #3; rst = 1'b0;
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("post_rst_ready", in_ready, 1'b0);
        chk("post_rst_we", imem_we, 1'b0);
        chk("post_rst_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
